rx_engine: RTL

UART receive engine, the receive-side counterpart of the transmit engine in the full-UART design. It deserialises the `rx` line using the same `eight`/`pen`/`ohel`/`baud` configuration as the transmitter. It presents one received character with status flags to the host-side read path. It sits between the board RX pin and the UART top-level register/LED interface.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/rx_engine_if.sv | 27 ++
 rtl/rx_bit_timer.sv | 33 +++
 rtl/rx_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: bit-time table, receiver state encoding and
// frame-length helpers used by the receive engine and its bit timer.
package uart_pkg;

  localparam int CNT_W = 19;   // bit-time counter width
  localparam int SR_W  = 10;   // receive shift register: up to 8 data + parity + stop
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RECV  = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  // Clock cycles per bit for each baud selector at 100 MHz.
  function automatic logic [CNT_W-1:0] baud_count(input logic [3:0] sel);
    logic [CNT_W-1:0] cnt;
    case (sel)
      4'h0:    cnt = 19'd333333;
      4'h1:    cnt = 19'd83333;
      4'h2:    cnt = 19'd41667;
      4'h3:    cnt = 19'd20833;
      4'h4:    cnt = 19'd10417;
      4'h5:    cnt = 19'd5208;
      4'h6:    cnt = 19'd2604;
      4'h7:    cnt = 19'd1736;
      4'h8:    cnt = 19'd868;
      4'h9:    cnt = 19'd434;
      4'hA:    cnt = 19'd217;
      default: cnt = 19'd109;
    endcase
    return cnt;
  endfunction

  // Bits sampled after the start bit: data (7/8) + optional parity + stop.
  function automatic logic [3:0] frame_payload_bits(input logic eight, input logic pen);
    return 4'd7 + {3'b000, eight} + {3'b000, pen} + 4'd1;
  endfunction

endpackage

// File: rtl/rx_engine_if.sv
// Host-side and line-side signals of the UART receive engine, bundled so
// the engine and its user share one definition.
interface rx_engine_if;
  logic       rx;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic [3:0] baud;
  logic       read;
  logic [7:0] data;
  logic       rxrdy;
  logic       perr;
  logic       ferr;
  logic       ovf;

  // Side that drives the line and configuration and consumes characters.
  modport master (
    output rx, eight, pen, ohel, baud, read,
    input  data, rxrdy, perr, ferr, ovf
  );

  // The receive engine itself.
  modport slave (
    input  rx, eight, pen, ohel, baud, read,
    output data, rxrdy, perr, ferr, ovf
  );
endinterface

// File: rtl/rx_bit_timer.sv
// Loadable bit-time down-counter. Loading N produces a one-cycle tick N
// cycles later; a half load uses N/2. Idles at zero with no tick.
module rx_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_half,
  input  logic             load_full,
  input  logic [CNT_W-1:0] full_count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_reg;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load_full) begin
      cnt_reg <= full_count;
    end else if (load_half) begin
      cnt_reg <= full_count >> 1;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - ONE;
    end
  end

  assign tick = (cnt_reg == ONE);

endmodule

// File: rtl/rx_engine.sv
// UART receive engine: synchronises rx, detects the start edge, samples
// each bit at mid-bit, checks parity and stop, and holds one character
// with status flags until the host reads it.
module rx_engine
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2   // at least 2
) (
  input  logic       clk,
  input  logic       rst,
  rx_engine_if.slave bus
);

  // ---------------- input synchroniser ----------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic                   rx_d_reg;
  logic                   fall;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic stage_in;
      logic q_reg;
      if (gi == 0) begin : g_first
        assign stage_in = bus.rx;
      end else begin : g_rest
        assign stage_in = sync_reg[gi-1];
      end
      // One synchroniser stage, reset to the idle line level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q_reg <= 1'b1;
        else     q_reg <= stage_in;
      end
      assign sync_reg[gi] = q_reg;
    end
  endgenerate

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // Previous synchronised level for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_d_reg <= 1'b1;
    else     rx_d_reg <= rx_s;
  end

  // A held-low line never re-triggers: a new edge needs a 1 first.
  assign fall = rx_d_reg & ~rx_s;

  // ---------------- control ----------------
  rx_state_t        state_reg, state_next;
  logic             latch_cfg;
  logic             start_ok;
  logic             load_full;
  logic             sample;
  logic             done;
  logic             tick;

  logic             eight_reg, pen_reg, ohel_reg;
  logic [CNT_W-1:0] full_count_reg;
  logic [CNT_W-1:0] timer_count;
  logic [3:0]       bits_left_reg;
  logic [SR_W-1:0]  shift_reg;

  // The half-bit load happens in the same cycle the configuration is
  // latched, so it must see the live baud selector.
  assign timer_count = latch_cfg ? baud_count(bus.baud) : full_count_reg;

  rx_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_half  (latch_cfg),
    .load_full  (load_full),
    .full_count (timer_count),
    .tick       (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state_reg;
    latch_cfg  = 1'b0;
    start_ok   = 1'b0;
    load_full  = 1'b0;
    sample     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fall) begin
          state_next = ST_START;
          latch_cfg  = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next = ST_RECV;
            start_ok   = 1'b1;
            load_full  = 1'b1;
          end else begin
            state_next = ST_IDLE;   // false start
          end
        end
      end
      ST_RECV: begin
        if (tick) begin
          sample = 1'b1;
          if (bits_left_reg == 4'd1) state_next = ST_DONE;
          else                       load_full  = 1'b1;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame configuration, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eight_reg      <= 1'b0;
      pen_reg        <= 1'b0;
      ohel_reg       <= 1'b0;
      full_count_reg <= '0;
      bits_left_reg  <= '0;
      shift_reg      <= '0;
    end else begin
      if (latch_cfg) begin
        eight_reg      <= bus.eight;
        pen_reg        <= bus.pen;
        ohel_reg       <= bus.ohel;
        full_count_reg <= baud_count(bus.baud);
        shift_reg      <= '0;
      end
      if (start_ok) begin
        bits_left_reg <= frame_payload_bits(eight_reg, pen_reg);
      end
      if (sample) begin
        shift_reg     <= {rx_s, shift_reg[SR_W-1:1]};
        bits_left_reg <= bits_left_reg - 4'd1;
      end
    end
  end

  // ---------------- frame decode ----------------
  // Samples enter at the MSB, so the stop bit always ends in the top bit
  // and the first data bit sits (SR_W - payload) places up.
  logic [3:0]        payload_bits;
  logic [8:0]        aligned;
  logic [DATA_W-1:0] data_next;
  logic              parity_bit;
  logic              perr_next;
  logic              ferr_next;

  assign payload_bits = frame_payload_bits(eight_reg, pen_reg);
  assign aligned      = 9'(shift_reg >> (4'(SR_W) - payload_bits));
  assign data_next    = eight_reg ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign parity_bit   = eight_reg ? aligned[8] : aligned[7];
  assign perr_next    = pen_reg & ((^data_next ^ parity_bit) != ohel_reg);
  assign ferr_next    = ~shift_reg[SR_W-1];

  // ---------------- host-facing outputs ----------------
  logic [DATA_W-1:0] data_reg;
  logic              rxrdy_reg, perr_reg, ferr_reg, ovf_reg;

  // A completing frame takes priority over a simultaneous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      rxrdy_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (done) begin
      data_reg  <= data_next;
      rxrdy_reg <= 1'b1;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      ovf_reg   <= rxrdy_reg & ~bus.read;
    end else if (bus.read) begin
      rxrdy_reg <= 1'b0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end
  end

  assign bus.data  = data_reg;
  assign bus.rxrdy = rxrdy_reg;
  assign bus.perr  = perr_reg;
  assign bus.ferr  = ferr_reg;
  assign bus.ovf   = ovf_reg;

endmodule
